shift_unit_arbiter: RTL and testbench

//  Shares one logical_left_shift datapath between two requesters: ALU issue (req0) and mult/div sequencer (req1).

---
 rtl/shift_unit_arbiter_pkg.sv | 14 +
 rtl/shift_unit_arbiter_shift.sv | 27 ++
 rtl/shift_unit_arbiter.sv | 120 ++++++++++++
 tb/tb_shift_unit_arbiter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_unit_arbiter_pkg.sv
// Shared constants for the shift unit arbiter: datapath widths, requester id
// encodings and arbitration mode encodings.
package shift_unit_arbiter_pkg;

    localparam int SUA_DATA_W  = 32;
    localparam int SUA_SHAMT_W = 5;

    localparam logic REQ_ALU = 1'b0;
    localparam logic REQ_MD  = 1'b1;

    localparam int PRIO_RR    = 0;
    localparam int PRIO_FIXED = 1;

endpackage

// File: rtl/shift_unit_arbiter_shift.sv
// Logarithmic barrel shifter: logical left shift with zero fill, one mux
// level per shift-amount bit.
module logical_left_shift
    import shift_unit_arbiter_pkg::*;
#(
    parameter int DATA_W  = SUA_DATA_W,
    parameter int SHAMT_W = SUA_SHAMT_W
) (
    input  logic [DATA_W-1:0]  i_data,
    input  logic [SHAMT_W-1:0] i_shamt,
    output logic [DATA_W-1:0]  o_data
);

    logic [DATA_W-1:0] w_stage;

    always_comb begin
        w_stage = i_data;
        for (int i = 0; i < SHAMT_W; i++) begin
            if (i_shamt[i]) begin
                w_stage = w_stage << (1 << i);
            end
        end
    end

    assign o_data = w_stage;

endmodule

// File: rtl/shift_unit_arbiter.sv
// Two-requester arbiter in front of a shared left shifter, built as a
// two-stage valid/ready pipeline (operand register, result register).
module shift_unit_arbiter
    import shift_unit_arbiter_pkg::*;
#(
    parameter int DATA_W    = SUA_DATA_W,
    parameter int SHAMT_W   = SUA_SHAMT_W,
    parameter int PRIO_MODE = PRIO_RR
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [DATA_W-1:0]  req0_data,
    input  logic [SHAMT_W-1:0] req0_shamt,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [DATA_W-1:0]  req1_data,
    input  logic [SHAMT_W-1:0] req1_shamt,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [DATA_W-1:0]  rsp_data,
    output logic               rsp_id,
    output logic               idle
);

    logic               r_a_valid;
    logic [DATA_W-1:0]  r_a_data;
    logic [SHAMT_W-1:0] r_a_shamt;
    logic               r_a_id;
    logic               r_b_valid;
    logic [DATA_W-1:0]  r_b_data;
    logic               r_b_id;
    logic               r_last_grant;

    logic               w_b_take;
    logic               w_a_free;
    logic               w_grant0;
    logic               w_grant1;
    logic [DATA_W-1:0]  w_shifted;

    assign w_b_take = r_a_valid & (~r_b_valid | rsp_ready);
    assign w_a_free = ~r_a_valid | w_b_take;

    // Ready never feeds back into valid; grants are also held off while reset is asserted.
    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (w_a_free && reset) begin
            if (req0_valid && req1_valid) begin
                if (PRIO_MODE == PRIO_FIXED) begin
                    w_grant0 = 1'b1;
                end else if (r_last_grant == REQ_MD) begin
                    w_grant0 = 1'b1;
                end else begin
                    w_grant1 = 1'b1;
                end
            end else if (req0_valid) begin
                w_grant0 = 1'b1;
            end else if (req1_valid) begin
                w_grant1 = 1'b1;
            end
        end
    end

    logical_left_shift #(
        .DATA_W  (DATA_W),
        .SHAMT_W (SHAMT_W)
    ) u_shift (
        .i_data  (r_a_data),
        .i_shamt (r_a_shamt),
        .o_data  (w_shifted)
    );

    // Stage A: operand register, refilled in the same cycle it drains into B.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_a_valid    <= 1'b0;
            r_a_data     <= '0;
            r_a_shamt    <= '0;
            r_a_id       <= REQ_ALU;
            r_last_grant <= REQ_MD;
        end else begin
            if (w_grant0 || w_grant1) begin
                r_a_valid    <= 1'b1;
                r_a_data     <= w_grant1 ? req1_data  : req0_data;
                r_a_shamt    <= w_grant1 ? req1_shamt : req0_shamt;
                r_a_id       <= w_grant1 ? REQ_MD : REQ_ALU;
                r_last_grant <= w_grant1 ? REQ_MD : REQ_ALU;
            end else if (w_b_take) begin
                r_a_valid <= 1'b0;
            end
        end
    end

    // Stage B: result register, held stable while the consumer stalls.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_b_valid <= 1'b0;
            r_b_data  <= '0;
            r_b_id    <= REQ_ALU;
        end else begin
            if (w_b_take) begin
                r_b_valid <= 1'b1;
                r_b_data  <= w_shifted;
                r_b_id    <= r_a_id;
            end else if (rsp_ready) begin
                r_b_valid <= 1'b0;
            end
        end
    end

    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;
    assign rsp_valid  = r_b_valid;
    assign rsp_data   = r_b_data;
    assign rsp_id     = r_b_id;
    assign idle       = ~r_a_valid & ~r_b_valid;

endmodule

// File: tb/tb_shift_unit_arbiter.sv
// Directed bench for shift_unit_arbiter: one round-robin and one fixed-priority
// instance share stimulus; a negedge scoreboard checks every response.
module tb_shift_unit_arbiter;
    import shift_unit_arbiter_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid, rsp_ready;
    logic [31:0] req0_data, req1_data;
    logic [4:0]  req0_shamt, req1_shamt;

    logic        rrReq0Ready, rrReq1Ready, rrRspValid, rrRspId, rrIdle;
    logic [31:0] rrRspData;
    logic        fpReq0Ready, fpReq1Ready, fpRspValid, fpRspId, fpIdle;
    logic [31:0] fpRspData;

    int errors = 0;
    int checks = 0;
    int rspCount = 0;

    always #5 clock = ~clock;

    shift_unit_arbiter #(.DATA_W(32), .SHAMT_W(5), .PRIO_MODE(PRIO_RR)) dutRr (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(rrReq0Ready), .req0_data(req0_data), .req0_shamt(req0_shamt),
        .req1_valid(req1_valid), .req1_ready(rrReq1Ready), .req1_data(req1_data), .req1_shamt(req1_shamt),
        .rsp_valid(rrRspValid), .rsp_ready(rsp_ready), .rsp_data(rrRspData), .rsp_id(rrRspId), .idle(rrIdle)
    );

    shift_unit_arbiter #(.DATA_W(32), .SHAMT_W(5), .PRIO_MODE(PRIO_FIXED)) dutFp (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(fpReq0Ready), .req0_data(req0_data), .req0_shamt(req0_shamt),
        .req1_valid(req1_valid), .req1_ready(fpReq1Ready), .req1_data(req1_data), .req1_shamt(req1_shamt),
        .rsp_valid(fpRspValid), .rsp_ready(rsp_ready), .rsp_data(fpRspData), .rsp_id(fpRspId), .idle(fpIdle)
    );

    logic monEn  = 1'b0;
    logic monSel = 1'b0;
    wire        monR0       = monSel ? fpReq0Ready : rrReq0Ready;
    wire        monR1       = monSel ? fpReq1Ready : rrReq1Ready;
    wire        monRspValid = monSel ? fpRspValid  : rrRspValid;
    wire [31:0] monRspData  = monSel ? fpRspData   : rrRspData;
    wire        monRspId    = monSel ? fpRspId     : rrRspId;
    wire        monIdle     = monSel ? fpIdle      : rrIdle;

    typedef struct packed {
        logic        id;
        logic [31:0] data;
    } exp_t;
    exp_t sbq[$];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic v0, input logic [31:0] d0, input logic [4:0] s0,
                                 input logic v1, input logic [31:0] d1, input logic [4:0] s1,
                                 input logic rr);
        req0_valid = v0; req0_data = d0; req0_shamt = s0;
        req1_valid = v1; req1_data = d1; req1_shamt = s1;
        rsp_ready  = rr;
    endtask

    task automatic nextCycle();
        @(posedge clock);
        #1;
    endtask

    // Responses are popped before this cycle's grant is pushed, so FIFO order is grant order.
    always @(negedge clock) begin : scoreboard
        exp_t e;
        if (monEn) begin
            checkOutput("one_ready", {31'b0, monR0 & monR1}, 32'h0);
            if (monRspValid && rsp_ready) begin
                rspCount++;
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL sb_unexpected: got rsp 0x%08h, expected no response", monRspData);
                end else begin
                    e = sbq.pop_front();
                    checkOutput("sb_data", monRspData, e.data);
                    checkOutput("sb_id", {31'b0, monRspId}, {31'b0, e.id});
                end
            end
            if (monR0) sbq.push_back(exp_t'({1'b0, req0_data << req0_shamt}));
            if (monR1) sbq.push_back(exp_t'({1'b1, req1_data << req1_shamt}));
        end
    end

    task automatic doReset(input logic sel);
        monEn = 1'b0;
        reset = 1'b0;
        applyStimulus(1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 5'd0, 1'b1);
        repeat (2) nextCycle();
        reset = 1'b1;
        sbq.delete();
        rspCount = 0;
        monSel = sel;
        monEn = 1'b1;
    endtask

    task automatic drain(input string name);
        rsp_ready = 1'b1;
        for (int i = 0; i < 30 && !(monIdle && sbq.size() == 0); i++) nextCycle();
        @(negedge clock);
        checkOutput({name, "_idle"}, {31'b0, monIdle}, 32'h1);
        checkOutput({name, "_sb_empty"}, sbq.size(), 32'h0);
        nextCycle();
    endtask

    typedef struct {
        logic        sel;
        logic [31:0] data;
        logic [4:0]  shamt;
        logic [31:0] expData;
    } vec_t;
    vec_t vecs[7];

    logic accepted;
    int   n;

    initial begin
        vecs[0] = '{1'b0, 32'h0000_0001, 5'd31, 32'h8000_0000};
        vecs[1] = '{1'b0, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF};
        vecs[2] = '{1'b1, 32'h1234_ABCD, 5'd16, 32'hABCD_0000};
        vecs[3] = '{1'b0, 32'hFFFF_FFFF, 5'd4,  32'hFFFF_FFF0};
        vecs[4] = '{1'b1, 32'h0000_00FF, 5'd8,  32'h0000_FF00};
        vecs[5] = '{1'b1, 32'h8000_0001, 5'd1,  32'h0000_0002};
        vecs[6] = '{1'b0, 32'h0000_0003, 5'd30, 32'hC000_0000};

        // Reset with both stages full: outputs clear immediately, req0 wins first.
        doReset(1'b0);
        monEn = 1'b0;
        applyStimulus(1'b0, 32'h0, 5'd0, 1'b1, 32'h0000_0005, 5'd8, 1'b0);
        repeat (3) nextCycle();
        @(negedge clock);
        checkOutput("full_idle", {31'b0, rrIdle}, 32'h0);
        checkOutput("full_rsp_valid", {31'b0, rrRspValid}, 32'h1);
        nextCycle();
        reset = 1'b0;
        applyStimulus(1'b1, 32'h0000_0007, 5'd1, 1'b1, 32'h0000_0009, 5'd1, 1'b0);
        @(negedge clock);
        checkOutput("rst_rsp_valid", {31'b0, rrRspValid}, 32'h0);
        checkOutput("rst_idle", {31'b0, rrIdle}, 32'h1);
        checkOutput("rst_rsp_data", rrRspData, 32'h0);
        checkOutput("rst_rsp_id", {31'b0, rrRspId}, 32'h0);
        checkOutput("rst_req0_ready", {31'b0, rrReq0Ready}, 32'h0);
        checkOutput("rst_req1_ready", {31'b0, rrReq1Ready}, 32'h0);
        nextCycle();
        reset = 1'b1;
        @(negedge clock);
        checkOutput("first_rr_req0", {31'b0, rrReq0Ready}, 32'h1);
        checkOutput("first_rr_req1", {31'b0, rrReq1Ready}, 32'h0);
        checkOutput("first_fp_req0", {31'b0, fpReq0Ready}, 32'h1);
        checkOutput("first_fp_req1", {31'b0, fpReq1Ready}, 32'h0);
        nextCycle();

        // Single ops from the vector table, two edges from grant to response.
        doReset(1'b0);
        foreach (vecs[k]) begin
            applyStimulus(~vecs[k].sel, vecs[k].data, vecs[k].shamt,
                          vecs[k].sel, vecs[k].data, vecs[k].shamt, 1'b1);
            @(negedge clock);
            checkOutput($sformatf("vec%0d_ready", k),
                        {31'b0, vecs[k].sel ? rrReq1Ready : rrReq0Ready}, 32'h1);
            nextCycle();
            applyStimulus(1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 5'd0, 1'b1);
            nextCycle();
            @(negedge clock);
            checkOutput($sformatf("vec%0d_valid", k), {31'b0, rrRspValid}, 32'h1);
            checkOutput($sformatf("vec%0d_data", k), rrRspData, vecs[k].expData);
            checkOutput($sformatf("vec%0d_id", k), {31'b0, rrRspId}, {31'b0, vecs[k].sel});
            nextCycle();
        end
        drain("vec");

        // Round-robin contention at full throughput.
        doReset(1'b0);
        for (int k = 0; k < 10; k++) begin
            applyStimulus(k < 8, 32'h0000_0010 + k, 5'd1, k < 8, 32'h0000_0020 + k, 5'd2, 1'b1);
            @(negedge clock);
            if (k < 8) begin
                checkOutput($sformatf("rr%0d_req0", k), {31'b0, rrReq0Ready}, (k % 2 == 0) ? 32'h1 : 32'h0);
                checkOutput($sformatf("rr%0d_req1", k), {31'b0, rrReq1Ready}, (k % 2 == 1) ? 32'h1 : 32'h0);
            end
            if (k >= 2) checkOutput($sformatf("rr%0d_rsp_valid", k), {31'b0, rrRspValid}, 32'h1);
            nextCycle();
        end
        checkOutput("rr_rsp_count", rspCount, 32'd8);
        drain("rr");

        // Backpressure: two accepts fill the pipe, then the result holds still.
        doReset(1'b0);
        n = 0;
        for (int c = 0; c < 7; c++) begin
            applyStimulus(1'b1, 32'h11 * (n + 1), 5'd4, 1'b0, 32'h0, 5'd0, 1'b0);
            @(negedge clock);
            accepted = rrReq0Ready;
            checkOutput($sformatf("bp%0d_ready", c), {31'b0, rrReq0Ready}, (c < 2) ? 32'h1 : 32'h0);
            if (c >= 2) begin
                checkOutput($sformatf("bp%0d_valid", c), {31'b0, rrRspValid}, 32'h1);
                checkOutput($sformatf("bp%0d_data", c), rrRspData, 32'h0000_0110);
            end
            nextCycle();
            if (accepted) n++;
        end
        for (int c = 0; c < 12 && n < 4; c++) begin
            applyStimulus(1'b1, 32'h11 * (n + 1), 5'd4, 1'b0, 32'h0, 5'd0, 1'b1);
            @(negedge clock);
            accepted = rrReq0Ready;
            nextCycle();
            if (accepted) n++;
        end
        checkOutput("bp_accepted", n, 32'd4);
        applyStimulus(1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 5'd0, 1'b1);
        drain("bp");
        checkOutput("bp_rsp_count", rspCount, 32'd4);

        // Fixed priority: req1 starves until req0 drops.
        doReset(1'b1);
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1'b1, 32'h0000_0100 + k, 5'd3, 1'b1, 32'h0000_0200 + k, 5'd5, 1'b1);
            @(negedge clock);
            checkOutput($sformatf("fp%0d_req0", k), {31'b0, fpReq0Ready}, 32'h1);
            checkOutput($sformatf("fp%0d_req1", k), {31'b0, fpReq1Ready}, 32'h0);
            nextCycle();
        end
        applyStimulus(1'b0, 32'h0, 5'd0, 1'b1, 32'h0000_0300, 5'd5, 1'b1);
        @(negedge clock);
        checkOutput("fp_drop_req1", {31'b0, fpReq1Ready}, 32'h1);
        nextCycle();
        applyStimulus(1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 5'd0, 1'b1);
        drain("fp");
        checkOutput("fp_rsp_count", rspCount, 32'd7);

        monEn = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
